key_expansion_ctrl: RTL and testbench

//  AES-128 key-schedule sequencer. Holds one instance of rotWord_subBytes and reuses it.

---
 rtl/key_expansion_ctrl.sv | 252 +++++++++++++++++++++++++
 tb/tb_key_expansion_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_expansion_ctrl.sv
// ---------------------------------------------------------------------------
// key_expansion_ctrl
//
// AES-128 key-schedule sequencer. A 128-bit cipher key is expanded into round
// keys 0..NUM_ROUNDS, one 32-bit word per cycle, reusing a single
// RotWord/SubWord unit whose input is always w3. Each completed round key is
// presented on a valid/ready stream to the cipher datapath.
//
// Parameters
//   NUM_ROUNDS  last round key index (1..10, 10 for full AES-128)
//   ROUND_W     width of round-index fields, 2**ROUND_W > NUM_ROUNDS
//
// Ports
//   clk         in   1        rising-edge clock
//   rst         in   1        asynchronous active-high reset
//   start       in   1        request an expansion, honoured only in IDLE
//   cipherKey   in   128      key to expand, word0 in [127:96]
//   busy        out  1        expansion in progress
//   rkValid     out  1        roundKey/rkRound hold a round key
//   rkReady     in   1        consumer takes the round key when rkValid is high
//   rkRound     out  ROUND_W  index of the presented round key
//   roundKey    out  128      current round key {w0,w1,w2,w3}
//   done        out  1        one-cycle pulse after the last round key is taken
//
// Optional feature, enabled by defining KEY_STORE_EN:
//   keeps a copy of every round key and adds the ports
//   rdRound     in   ROUND_W  round index to read back
//   rdKey       out  128      stored key for rdRound (0 when out of range)
//   storeValid  out  1        store holds a complete schedule
// ---------------------------------------------------------------------------
module key_expansion_ctrl #(
    parameter int NUM_ROUNDS = 10,
    parameter int ROUND_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [127:0]       cipherKey,
    output logic               busy,
    output logic               rkValid,
    input  logic               rkReady,
    output logic [ROUND_W-1:0] rkRound,
    output logic [127:0]       roundKey,
    output logic               done
`ifdef KEY_STORE_EN
    ,
    input  logic [ROUND_W-1:0] rdRound,
    output logic [127:0]       rdKey,
    output logic               storeValid
`endif
);

    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS);

    // AES forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        EXPAND
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] w3;
    logic [1:0]  word_idx;
    logic [7:0]  rcon;
    logic [31:0] sub_word;

    logic        accept;
    logic        handshake;
    logic        last_taken;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[(255 - int'(b)) * 8 +: 8];
    endfunction

    // Rotate one byte left, then substitute every byte.
    function automatic logic [31:0] rot_word_sub_bytes(input logic [31:0] w);
        logic [31:0] r;
        r = {w[23:0], w[31:24]};
        return {sbox(r[31:24]), sbox(r[23:16]), sbox(r[15:8]), sbox(r[7:0])};
    endfunction

    // Multiply by x in GF(2^8); steps rcon through 01 02 04 .. 80 1B 36.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // The only RotWord/SubWord hardware; it always looks at w3 and is only
    // consumed while word 0 of a new round is being produced.
    assign sub_word = rot_word_sub_bytes(w3);

    assign roundKey = {w0, w1, w2, w3};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and stream control. A start that lands in the cycle done is
    // pulsing is dropped so that one expansion never chains into the next.
    always_comb begin
        state_next = state;
        rkValid    = 1'b0;
        busy       = 1'b0;
        accept     = 1'b0;
        handshake  = 1'b0;
        last_taken = 1'b0;
        case (state)
            IDLE: begin
                if (start && !done) begin
                    accept     = 1'b1;
                    state_next = EMIT;
                end
            end
            EMIT: begin
                rkValid = 1'b1;
                busy    = 1'b1;
                if (rkReady) begin
                    handshake = 1'b1;
                    if (rkRound == LAST_ROUND) begin
                        last_taken = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = EXPAND;
                    end
                end
            end
            EXPAND: begin
                busy = 1'b1;
                if (word_idx == 2'd3) begin
                    state_next = EMIT;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Key words, round counter and rcon. During EXPAND each cycle rewrites one
    // word using the word just produced, so after four cycles {w0..w3} is the
    // next round key. Nothing here moves while EMIT waits for rkReady.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w0       <= '0;
            w1       <= '0;
            w2       <= '0;
            w3       <= '0;
            word_idx <= 2'd0;
            rcon     <= 8'h01;
            rkRound  <= '0;
            done     <= 1'b0;
        end else begin
            done <= last_taken;
            case (state)
                IDLE: begin
                    if (accept) begin
                        w0       <= cipherKey[127:96];
                        w1       <= cipherKey[95:64];
                        w2       <= cipherKey[63:32];
                        w3       <= cipherKey[31:0];
                        rkRound  <= '0;
                        rcon     <= 8'h01;
                        word_idx <= 2'd0;
                    end
                end
                EMIT: begin
                    if (handshake) begin
                        word_idx <= 2'd0;
                    end
                end
                EXPAND: begin
                    word_idx <= word_idx + 2'd1;
                    case (word_idx)
                        2'd0: w0 <= w0 ^ sub_word ^ {rcon, 24'h000000};
                        2'd1: w1 <= w1 ^ w0;
                        2'd2: w2 <= w2 ^ w1;
                        default: begin
                            w3      <= w3 ^ w2;
                            rkRound <= rkRound + 1'b1;
                            rcon    <= xtime(rcon);
                        end
                    endcase
                end
                default: begin
                end
            endcase
        end
    end

`ifdef KEY_STORE_EN
    logic [127:0] key_store [0:NUM_ROUNDS];

    // Every accepted round key is copied to its slot. Slots survive a new
    // start and are only wiped by reset; storeValid tells the reader whether
    // the contents belong to a finished schedule.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                key_store[i] <= '0;
            end
            storeValid <= 1'b0;
        end else begin
            if (handshake) begin
                key_store[rkRound] <= roundKey;
            end
            if (accept) begin
                storeValid <= 1'b0;
            end else if (last_taken) begin
                storeValid <= 1'b1;
            end
        end
    end

    // Combinational read port; indices past the last round read as zero.
    always_comb begin
        rdKey = '0;
        if (rdRound <= LAST_ROUND) begin
            rdKey = key_store[rdRound];
        end
    end
`endif

endmodule

// File: tb/tb_key_expansion_ctrl.sv
// ---------------------------------------------------------------------------
// tb_key_expansion_ctrl
//
// Directed bench for key_expansion_ctrl. Each requested expansion pushes its
// expected round keys onto a scoreboard; every presented round key is
// compared against the head entry, which is popped on the handshake.
// ---------------------------------------------------------------------------
module tb_key_expansion_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] cipherKey;
    logic         busy;
    logic         rkValid;
    logic         rkReady;
    logic [3:0]   rkRound;
    logic [127:0] roundKey;
    logic         done;
`ifdef KEY_STORE_EN
    logic [3:0]   rdRound;
    logic [127:0] rdKey;
    logic         storeValid;
`endif

    typedef struct {
        int           round;
        logic [127:0] key;
        bit           checkKey;
    } sb_item_t;

    sb_item_t scoreboard[$];

    int errors = 0;
    int checks = 0;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ZERO_KEY = 128'h0;

    key_expansion_ctrl #(
        .NUM_ROUNDS(10),
        .ROUND_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .cipherKey(cipherKey),
        .busy(busy),
        .rkValid(rkValid),
        .rkReady(rkReady),
        .rkRound(rkRound),
        .roundKey(roundKey),
        .done(done)
`ifdef KEY_STORE_EN
        ,
        .rdRound(rdRound),
        .rdKey(rdKey),
        .storeValid(storeValid)
`endif
    );

    always #5 clk = ~clk;

    // FIPS-197 Appendix A.1 round keys.
    function automatic logic [127:0] fipsRound(input int r);
        case (r)
            0:       return 128'h2b7e151628aed2a6abf7158809cf4f3c;
            1:       return 128'ha0fafe1788542cb123a339392a6c7605;
            2:       return 128'hf2c295f27a96b9435935807a7359f67f;
            3:       return 128'h3d80477d4716fe3e1e237e446d7a883b;
            4:       return 128'hef44a541a8525b7fb671253bdb0bad00;
            5:       return 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
            6:       return 128'h6d88a37a110b3efddbf98641ca0093fd;
            7:       return 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
            8:       return 128'head27321b58dbad2312bf5607f8d292f;
            9:       return 128'hac7766f319fadc2128d12941575c006e;
            default: return 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drives start for one cycle; returns at the negedge after the start was
    // sampled. For the all-zero key only rounds 0 and 1 carry a known value.
    task automatic applyStimulus(input logic [127:0] key, input bit pushExpect);
        sb_item_t item;
        @(negedge clk);
        start     = 1'b1;
        cipherKey = key;
        if (pushExpect) begin
            for (int r = 0; r <= 10; r++) begin
                item.round    = r;
                item.checkKey = (key != ZERO_KEY) || (r <= 1);
                if (key == ZERO_KEY) begin
                    item.key = (r == 1) ? 128'h62636363626363636263636362636363 : 128'h0;
                end else begin
                    item.key = fipsRound(r);
                end
                scoreboard.push_back(item);
            end
        end
        @(negedge clk);
        start     = 1'b0;
        cipherKey = ~key;
    endtask

    // Services the stream until done. cycles counts clock edges from the
    // edge that sampled start to the edge that raised done.
    task automatic runExpansion(input int stallRound, input int stallCycles,
                                input bit pulseStart, input bit checkRcon,
                                output int cycles);
        int       stallLeft;
        bit       seenDone;
        bit       pulsed2;
        bit       pulsed6;
        sb_item_t item;
        stallLeft = stallCycles;
        seenDone  = 1'b0;
        pulsed2   = 1'b0;
        pulsed6   = 1'b0;
        cycles    = 0;
        while (!seenDone && cycles < 400) begin
            start = 1'b0;
            if (done) begin
                seenDone = 1'b1;
                checkOutput("busy_at_done", 128'(busy), 128'(0));
            end else if (rkValid) begin
                checks++;
                assert (scoreboard.size() != 0) else begin
                    errors++;
                    $error("[TB] FAIL sb_underflow: observed round %0d with empty scoreboard expected none",
                           rkRound);
                end
                if (scoreboard.size() != 0) begin
                    item = scoreboard[0];
                    checkOutput($sformatf("rkRound_%0d", item.round), 128'(rkRound), 128'(item.round));
                    if (item.checkKey) begin
                        checkOutput($sformatf("roundKey_%0d", item.round), roundKey, item.key);
                    end
                    if (checkRcon && rkRound == 4'd8) begin
                        checkOutput("rcon_round9", 128'(dut.rcon), 128'(8'h1B));
                    end
                    if (item.round == stallRound && stallLeft > 0) begin
                        rkReady = 1'b0;
                        stallLeft--;
                    end else begin
                        rkReady = 1'b1;
                        void'(scoreboard.pop_front());
                    end
                    if (pulseStart && rkRound == 4'd2 && !pulsed2) begin
                        start     = 1'b1;
                        cipherKey = 128'h00112233445566778899aabbccddeeff;
                        pulsed2   = 1'b1;
                    end
                    if (pulseStart && rkRound == 4'd6 && !pulsed6) begin
                        start     = 1'b1;
                        cipherKey = 128'hffeeddccbbaa99887766554433221100;
                        pulsed6   = 1'b1;
                    end
                end
            end else begin
                rkReady = 1'b1;
            end
            if (!seenDone) begin
                @(negedge clk);
                cycles++;
            end
        end
        start   = 1'b0;
        rkReady = 1'b1;
        checks++;
        assert (seenDone) else begin
            errors++;
            $error("[TB] FAIL done_timeout: observed no done after %0d cycles expected done", cycles);
        end
        checkOutput("sb_empty", 128'(scoreboard.size()), 128'(0));
    endtask

    initial begin
        int cycles;
        int budget;

        rst       = 1'b1;
        start     = 1'b0;
        rkReady   = 1'b1;
        cipherKey = '0;
`ifdef KEY_STORE_EN
        rdRound   = '0;
`endif
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_busy", 128'(busy), 128'(0));
        checkOutput("reset_rkValid", 128'(rkValid), 128'(0));
        checkOutput("reset_done", 128'(done), 128'(0));
        checkOutput("reset_rkRound", 128'(rkRound), 128'(0));
        checkOutput("reset_roundKey", roundKey, 128'h0);
        checkOutput("reset_rcon", 128'(dut.rcon), 128'(8'h01));
        rst = 1'b0;

        $display("[TB] scenario 1: FIPS-197 key, consumer always ready");
        applyStimulus(FIPS_KEY, 1'b1);
        checkOutput("latency_rkValid", 128'(rkValid), 128'(1));
        checkOutput("latency_busy", 128'(busy), 128'(1));
        runExpansion(-1, 0, 1'b0, 1'b0, cycles);
        checkOutput("s1_cycles", 128'(cycles), 128'(51));
        // Start presented while done pulses must be dropped.
        start     = 1'b1;
        cipherKey = ZERO_KEY;
        @(negedge clk);
        start = 1'b0;
        checkOutput("done_pulse_width", 128'(done), 128'(0));
        checkOutput("start_at_done_rkValid", 128'(rkValid), 128'(0));
        checkOutput("start_at_done_busy", 128'(busy), 128'(0));

        $display("[TB] scenario 2: stall round 3 for 7 cycles");
        applyStimulus(FIPS_KEY, 1'b1);
        runExpansion(3, 7, 1'b0, 1'b0, cycles);
        checkOutput("s2_cycles", 128'(cycles), 128'(58));

        $display("[TB] scenario 3: start pulses while busy");
        applyStimulus(FIPS_KEY, 1'b1);
        runExpansion(-1, 0, 1'b1, 1'b0, cycles);
        checkOutput("s3_cycles", 128'(cycles), 128'(51));

        $display("[TB] scenario 4: reset during expansion of round 5");
        applyStimulus(FIPS_KEY, 1'b0);
        rkReady = 1'b1;
        budget  = 0;
        while (!(busy && !rkValid && rkRound == 4'd4) && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("s4_reached_round5", 128'(budget < 100), 128'(1));
        rst = 1'b1;
        #1;
        checkOutput("s4_busy", 128'(busy), 128'(0));
        checkOutput("s4_rkValid", 128'(rkValid), 128'(0));
        checkOutput("s4_done", 128'(done), 128'(0));
        checkOutput("s4_rkRound", 128'(rkRound), 128'(0));
        checkOutput("s4_roundKey", roundKey, 128'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("s4_no_done", 128'(done), 128'(0));
        checkOutput("s4_idle", 128'(busy), 128'(0));
        applyStimulus(FIPS_KEY, 1'b1);
        runExpansion(-1, 0, 1'b0, 1'b0, cycles);
        checkOutput("s4_cycles", 128'(cycles), 128'(51));

`ifdef KEY_STORE_EN
        $display("[TB] scenario 6: key store readback");
        @(negedge clk);
        checkOutput("storeValid", 128'(storeValid), 128'(1));
        rdRound = 4'd10;
        #1;
        checkOutput("rdKey_10", rdKey, fipsRound(10));
        rdRound = 4'd1;
        #1;
        checkOutput("rdKey_1", rdKey, fipsRound(1));
        rdRound = 4'd12;
        #1;
        checkOutput("rdKey_12", rdKey, 128'h0);
`endif

        $display("[TB] scenario 5: all-zero key");
        applyStimulus(ZERO_KEY, 1'b1);
        runExpansion(-1, 0, 1'b0, 1'b1, cycles);
        checkOutput("s5_cycles", 128'(cycles), 128'(51));

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
